// File: rtl/step_move_controller.sv
// step_move_controller
// Accepts a move command (direction, step count, step period) and issues
// one-cycle step strobes with a held direction to the stepper phase driver.
// It tracks signed absolute position, waits a settle interval after the last
// step, and then pulses done. Abort ends a move at once and flags done as aborted.

module step_move_controller #(
    parameter int CNT_W      = 16,
    parameter int DIV_W      = 16,
    parameter int POS_W      = 24,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             drv_en,
    output logic             drv_dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left,
    output logic [POS_W-1:0] pos
);

    localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] stepsLeft_q, stepsLeft_d;
    logic [DIV_W-1:0] reload_q, reload_d;
    logic [DIV_W-1:0] periodCnt_q, periodCnt_d;
    logic [SET_W-1:0] settleCnt_q, settleCnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             drvEn_q, drvEn_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // A zero period runs at one step per cycle, so the reload value is period-1 floored at 0.
    logic [DIV_W-1:0] cmdReload;
    assign cmdReload = (cmd_period == '0) ? '0 : (cmd_period - DIV_W'(1));

    // State and datapath registers; reset drops any in-flight strobe and clears position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            stepsLeft_q <= '0;
            reload_q    <= '0;
            periodCnt_q <= '0;
            settleCnt_q <= '0;
            pos_q       <= '0;
            drvEn_q     <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            stepsLeft_q <= stepsLeft_d;
            reload_q    <= reload_d;
            periodCnt_q <= periodCnt_d;
            settleCnt_q <= settleCnt_d;
            pos_q       <= pos_d;
            drvEn_q     <= drvEn_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next-state logic: accept in IDLE, pace strobes in RUN, count down in SETTLE; abort wins over a due strobe.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        stepsLeft_d = stepsLeft_q;
        reload_d    = reload_q;
        periodCnt_d = periodCnt_q;
        settleCnt_d = settleCnt_q;
        pos_d       = pos_q;
        drvEn_d     = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d       = cmd_dir;
                    stepsLeft_d = cmd_steps;
                    reload_d    = cmdReload;
                    periodCnt_d = cmdReload;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (periodCnt_q == '0) begin
                    periodCnt_d = reload_q;
                    drvEn_d     = 1'b1;
                    stepsLeft_d = stepsLeft_q - CNT_W'(1);
                    pos_d       = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
                    if (stepsLeft_q == CNT_W'(1)) begin
                        state_d     = SETTLE;
                        settleCnt_d = SETTLE_LOAD;
                    end
                end else begin
                    periodCnt_d = periodCnt_q - DIV_W'(1);
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (settleCnt_q <= SET_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    settleCnt_d = settleCnt_q - SET_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers or the current state, so the driver sees no comb glitches from inputs.
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        drv_en     = drvEn_q;
        drv_dir    = dir_q;
        done       = done_q;
        aborted    = aborted_q;
        steps_left = stepsLeft_q;
        pos        = pos_q;
    end

endmodule

// File: tb/tb_step_move_controller.sv
// tb_step_move_controller
// Directed moves against step_move_controller with a 4-bit position so that
// wrap-around is reachable. Expected strobe and done events are queued when a
// command is issued and popped by an independent monitor on the falling edge.

module tb_step_move_controller;

    localparam int CNT_W  = 16;
    localparam int DIV_W  = 16;
    localparam int POS_W  = 4;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmdValid;
    logic             cmdReady;
    logic             cmdDir;
    logic [CNT_W-1:0] cmdSteps;
    logic [DIV_W-1:0] cmdPeriod;
    logic             abort;
    logic             drvEn;
    logic             drvDir;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] stepsLeft;
    logic [POS_W-1:0] pos;

    step_move_controller #(
        .CNT_W     (CNT_W),
        .DIV_W     (DIV_W),
        .POS_W     (POS_W),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_dir   (cmdDir),
        .cmd_steps (cmdSteps),
        .cmd_period(cmdPeriod),
        .abort     (abort),
        .drv_en    (drvEn),
        .drv_dir   (drvDir),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .steps_left(stepsLeft),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               isDone;
        int               edgeNo;
        logic [POS_W-1:0] pos;
        logic [CNT_W-1:0] stepsLeft;
        logic             dir;
        logic             aborted;
    } evt_t;

    evt_t             expQ[$];
    evt_t             monEvt;
    int               checks   = 0;
    int               failures = 0;
    int               edgeCnt  = 0;
    logic [POS_W-1:0] modelPos = '0;
    int               acc;

    // Rising-edge counter used to timestamp every expected event.
    always @(posedge clk) edgeCnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    function automatic void pushEvt(input bit isDone, input int edgeNo, input logic [POS_W-1:0] p,
                                    input logic [CNT_W-1:0] sl, input logic d, input logic ab);
        evt_t e;
        e.isDone    = isDone;
        e.edgeNo    = edgeNo;
        e.pos       = p;
        e.stepsLeft = sl;
        e.dir       = d;
        e.aborted   = ab;
        expQ.push_back(e);
    endfunction

    // Hand model of a full move: a strobe every P edges, then done SETTLE edges after the last strobe.
    function automatic void pushMove(input int accEdge, input logic dir, input int steps, input int period);
        int p;
        p = (period == 0) ? 1 : period;
        for (int i = 1; i <= steps; i++) begin
            modelPos = dir ? (modelPos - POS_W'(1)) : (modelPos + POS_W'(1));
            pushEvt(1'b0, accEdge + i * p, modelPos, CNT_W'(steps - i), dir, 1'b0);
        end
        pushEvt(1'b1, (steps == 0) ? accEdge : (accEdge + steps * p + SETTLE), modelPos, '0, dir, 1'b0);
    endfunction

    // Monitor: every strobe or done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (drvEn || done)) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedEvent: got drv_en=%0b done=%0b expected none (edge %0d)",
                         drvEn, done, edgeCnt);
            end else begin
                monEvt = expQ.pop_front();
                checkOutput("evtIsDone", 32'(done), 32'(monEvt.isDone));
                checkOutput("evtDrvEn", 32'(drvEn), 32'(!monEvt.isDone));
                checkOutput("evtEdge", 32'(edgeCnt), 32'(monEvt.edgeNo));
                checkOutput("evtPos", 32'(pos), 32'(monEvt.pos));
                checkOutput("evtStepsLeft", 32'(stepsLeft), 32'(monEvt.stepsLeft));
                checkOutput("evtDir", 32'(drvDir), 32'(monEvt.dir));
                checkOutput("evtBusy", 32'(busy), 32'(!monEvt.isDone));
                if (monEvt.isDone) begin
                    checkOutput("evtAborted", 32'(aborted), 32'(monEvt.aborted));
                    checkOutput("evtCmdReady", 32'(cmdReady), 32'd1);
                end
            end
        end
    end

    // Advance to 1 ns after the given rising edge.
    task automatic waitEdge(input int target);
        while (edgeCnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait, with a cycle budget, for the monitor to consume every expected event.
    task automatic waitIdle();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL waitIdleTimeout: got %0d pending events expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Present one command for a single cycle; caller must be 1 ns after a rising edge with the DUT idle.
    task automatic applyStimulus(input logic dir, input int steps, input int period,
                                 input bit doPush, output int accEdge);
        accEdge   = edgeCnt + 1;
        cmdDir    = dir;
        cmdSteps  = CNT_W'(steps);
        cmdPeriod = DIV_W'(period);
        cmdValid  = 1'b1;
        if (doPush) pushMove(accEdge, dir, steps, period);
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cmdReady"}, 32'(cmdReady), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_drvEn"}, 32'(drvEn), 32'd0);
        checkOutput({tag, "_drvDir"}, 32'(drvDir), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_aborted"}, 32'(aborted), 32'd0);
        checkOutput({tag, "_stepsLeft"}, 32'(stepsLeft), 32'd0);
        checkOutput({tag, "_pos"}, 32'(pos), 32'd0);
    endtask

    // Hard stop in case something blocks outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst       = 1'b1;
        cmdValid  = 1'b0;
        cmdDir    = 1'b0;
        cmdSteps  = '0;
        cmdPeriod = '0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("inReset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkReset("afterReset");

        // Forward 4 steps, period 3: strobes at +3,+6,+9,+12, done at +16.
        applyStimulus(1'b0, 4, 3, 1'b1, acc);
        checkOutput("fwdBusy", 32'(busy), 32'd1);
        checkOutput("fwdCmdReady", 32'(cmdReady), 32'd0);
        waitIdle();
        checkOutput("fwdPos", 32'(pos), 32'd4);

        // Reverse 3 steps with period 0: three back-to-back strobes, pos 4 -> 1.
        applyStimulus(1'b1, 3, 0, 1'b1, acc);
        checkOutput("revDrvDir", 32'(drvDir), 32'd1);
        waitIdle();
        checkOutput("revDirHeld", 32'(drvDir), 32'd1);
        checkOutput("revPos", 32'(pos), 32'd1);

        // Forward 5 steps period 2, abort sampled on the edge of the third strobe.
        applyStimulus(1'b0, 5, 2, 1'b0, acc);
        pushEvt(1'b0, acc + 2, 4'd2, 16'd4, 1'b0, 1'b0);
        pushEvt(1'b0, acc + 4, 4'd3, 16'd3, 1'b0, 1'b0);
        pushEvt(1'b1, acc + 6, 4'd3, 16'd3, 1'b0, 1'b1);
        modelPos = 4'd3;
        waitEdge(acc + 5);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abortCmdReady", 32'(cmdReady), 32'd1);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abortResidual", 32'(stepsLeft), 32'd3);
        checkOutput("abortDoneGone", 32'(done), 32'd0);
        checkOutput("abortFlagGone", 32'(aborted), 32'd0);

        // Zero-step reverse command with abort also high: accepted, no strobe, done next cycle.
        abort = 1'b1;
        applyStimulus(1'b1, 0, 5, 1'b1, acc);
        abort = 1'b0;
        checkOutput("zeroBusy", 32'(busy), 32'd0);
        checkOutput("zeroCmdReady", 32'(cmdReady), 32'd1);
        waitIdle();
        checkOutput("zeroPos", 32'(pos), 32'd3);

        // cmd_valid held through a move: the second command is taken only after done.
        cmdDir    = 1'b0;
        cmdSteps  = 16'd1;
        cmdPeriod = 16'd2;
        cmdValid  = 1'b1;
        acc       = edgeCnt + 1;
        pushMove(acc, 1'b0, 1, 2);
        pushMove(acc + 7, 1'b0, 2, 2);
        @(posedge clk);
        #1;
        cmdSteps = 16'd2;
        checkOutput("heldCmdReady", 32'(cmdReady), 32'd0);
        checkOutput("heldLatched", 32'(stepsLeft), 32'd1);
        waitEdge(acc + 7);
        cmdValid = 1'b0;
        checkOutput("heldSecondBusy", 32'(busy), 32'd1);
        checkOutput("heldSecondSteps", 32'(stepsLeft), 32'd2);
        waitIdle();
        checkOutput("heldPos", 32'(pos), 32'd6);

        // Wrap checks on a 4-bit position.
        applyStimulus(1'b0, 1, 1, 1'b1, acc);
        waitIdle();
        checkOutput("wrapPos7", 32'(pos), 32'(4'b0111));
        applyStimulus(1'b0, 1, 1, 1'b1, acc);
        waitIdle();
        checkOutput("wrapPos8", 32'(pos), 32'(4'b1000));
        applyStimulus(1'b1, 9, 1, 1'b1, acc);
        waitIdle();
        checkOutput("wrapNeg1", 32'(pos), 32'(4'b1111));
        applyStimulus(1'b0, 2, 1, 1'b1, acc);
        waitIdle();
        checkOutput("wrapPlus1", 32'(pos), 32'(4'b0001));

        // Reset asserted during SETTLE: immediate reset values and no done pulse.
        applyStimulus(1'b0, 1, 1, 1'b1, acc);
        waitEdge(acc + 2);
        checkOutput("preRstBusy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        expQ.delete();
        modelPos = '0;
        checkReset("midRst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitEdge(acc + 8);
        checkReset("postRst");

        // A command after reset release proceeds normally from pos 0.
        applyStimulus(1'b1, 2, 1, 1'b1, acc);
        waitIdle();
        checkOutput("postRstPos", 32'(pos), 32'(4'b1110));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_move_controller.md
# step_move_controller

Sequencing controller for the stepper phase driver. Accepts a move command (direction, step count, step period) over a valid/ready handshake and issues one-cycle step strobes plus a held direction to the phase driver at the commanded rate. Tracks absolute position, then holds a settle interval before reporting completion. Sits between the system command logic and the phase driver; it is the only block that drives the driver's enable and direction inputs.

## Interface

Parameters:
- CNT_W, 16, width of step count and steps-remaining.
- DIV_W, 16, width of step period in clock cycles.
- POS_W, 24, width of signed absolute position counter.
- SETTLE_CYC, 4, idle cycles after the last step before completion (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_dir  in  1  0 = forward (+1 per step), 1 = reverse (−1 per step).
- cmd_steps  in  CNT_W  number of steps to issue.
- cmd_period  in  DIV_W  clock cycles per step; 0 treated as 1.
- abort  in  1  stop current move immediately.
- drv_en  out  1  one-cycle step strobe to the phase driver.
- drv_dir  out  1  direction to the phase driver, held between commands.
- busy  out  1  move or settle in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done: move ended by abort; valid only while done=1.
- steps_left  out  CNT_W  steps not yet issued in current move.
- pos  out  POS_W  signed absolute position.

## Operation

- Reset values: cmd_ready=1, all other outputs 0, state IDLE, pos=0.
- States: IDLE, RUN, SETTLE.
- IDLE: command accepted on an edge where cmd_valid && cmd_ready. Latch dir, steps, period (0→1). drv_dir takes cmd_dir. steps_left takes cmd_steps. Load period counter with period−1, then go to RUN.
- IDLE with cmd_steps=0: accept, stay IDLE, issue no strobe, pulse done (aborted=0) after the next edge.
- RUN: the period counter decrements each cycle. On reaching 0 it reloads and issues a strobe. At the same edge, drv_en rises for one cycle, steps_left decrements, and pos changes by +1 (dir=0) or −1 (dir=1).
- After the strobe that brings steps_left to 0, go to SETTLE. The SETTLE counter loads with SETTLE_CYC.
- SETTLE: drv_en=0 and drv_dir held. When the counter expires, go to IDLE, pulse done with aborted=0, and raise cmd_ready.
- abort in RUN or SETTLE:
  - At the sampling edge, go to IDLE; busy=0, cmd_ready=1.
  - done=1 and aborted=1 for one cycle.
  - A strobe scheduled for that same edge is suppressed; pos and steps_left are not updated.
  - steps_left keeps the residual count until the next acceptance.
- abort in IDLE is ignored. If cmd_valid and abort are both high in IDLE, the command is accepted.
- busy = (state != IDLE). cmd_ready = (state == IDLE).
- pos wraps modulo 2^POS_W (two's complement). No saturation.
- drv_dir never changes while busy.

## Timing

- Acceptance edge = edge 0. drv_dir and busy are valid after edge 0.
- Strobes: drv_en is high for exactly one cycle after edges P, 2P, …, N·P (P = effective period, N = steps).
  - With P=1, drv_en stays high continuously for N cycles.
- pos and steps_left update at the same edges as the strobes.
- done is high for one cycle after edge N·P + SETTLE_CYC. busy falls and cmd_ready rises after the same edge.
- Latency from acceptance to done: N·P + SETTLE_CYC cycles.
- A new command may be accepted at the edge following done. Back-to-back moves therefore have a minimum of 1 cycle in IDLE.
- Reset mid-move: outputs return to reset values asynchronously. pos clears to 0 and any strobe in flight is dropped.

## Test plan

- Reset, then forward move with steps=4, period=3 -> drv_en pulses after edges 3,6,9,12; pos 0→4; steps_left 4→0; done after edge 16 (SETTLE_CYC=4); aborted=0.
- Reverse move with steps=3, period=0 from pos=4 -> strobes on 3 consecutive cycles; pos 4→1; drv_dir=1 held until next acceptance.
- Abort at the edge of the 3rd strobe in a steps=5, period=2 move -> only 2 strobes issued; pos +2; steps_left=3; done=aborted=1 for one cycle; cmd_ready=1 next cycle.
- Zero-step command -> no strobe, busy stays 0, done pulse one cycle after acceptance; cmd_valid held during RUN -> cmd_ready=0, command not consumed until after done.
- Wrap: preload pos to −1 via reverse moves with POS_W=4, then forward steps=2 -> pos wraps to +1 (4'b0001). Forward from 4'b0111 by 1 -> 4'b1000.
- Assert rst during SETTLE -> all outputs at reset values immediately; no done pulse; a command after rst release is accepted normally.
